// File: rtl/controlador_vga.sv
// controlador_vga: VGA timing generator (640x480 @ 800x525 by default).
//
// Keeps a horizontal pixel counter h and a vertical line counter v and
// derives every output from them through one register stage, so all
// outputs move together on the same edge, one cycle after the counter
// state they describe.
//
// Ports
//   clk          in   pixel clock, rising edge
//   reset        in   synchronous, active-high
//   hsync        out  horizontal sync, level set by H_POL (0 = active-low)
//   vsync        out  vertical sync, level set by V_POL (0 = active-low)
//   disp_ena     out  high inside the visible area only
//   col [9:0]    out  visible column, 0 outside the visible area
//   row [8:0]    out  visible row, 0 outside the visible area
//   line_start   out  one-cycle pulse on the first pixel of each line
//   frame_start  out  one-cycle pulse on pixel (0,0) of each frame
module controlador_vga #(
  parameter int   H_VISIVEL = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_VISIVEL = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic H_POL     = 1'b0,
  parameter logic V_POL     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       disp_ena,
  output logic [9:0] col,
  output logic [8:0] row,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIVEL + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIVEL + V_FP + V_SYNC + V_BP;

  // Boundaries pre-sized to the 10-bit counters
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIVEL);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIVEL + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIVEL + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIVEL);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIVEL + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIVEL + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  logic [9:0] h;
  logic [9:0] v;
  logic       visible;
  logic       h_sync_win;
  logic       v_sync_win;

  always_comb begin
    visible    = (h < H_VIS_END) && (v < V_VIS_END);
    h_sync_win = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
    v_sync_win = (v >= V_SYNC_BEG) && (v < V_SYNC_END);
  end

  // Counters
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= 10'd0;
      v <= 10'd0;
    end else if (h == H_LAST) begin
      h <= 10'd0;
      v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Output register: describes the counter state of the previous cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      disp_ena    <= 1'b0;
      col         <= 10'd0;
      row         <= 9'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= h_sync_win ? H_POL : ~H_POL;
      vsync       <= v_sync_win ? V_POL : ~V_POL;
      disp_ena    <= visible;
      col         <= visible ? h : 10'd0;
      row         <= visible ? v[8:0] : 9'd0;
      line_start  <= (h == 10'd0);
      frame_start <= (h == 10'd0) && (v == 10'd0);
    end
  end

endmodule

// File: tb/tb_controlador_vga.sv
// Bench for controlador_vga: three instances share clock and reset.
//   d0: default timing and polarity
//   d1: default timing, inverted sync polarity
//   d2: reduced timing (16 x 12 total) so whole frames fit in a short run
module tb_controlador_vga;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;

  logic       d0_hs, d0_vs, d0_de, d0_ls, d0_fs;
  logic [9:0] d0_col;
  logic [8:0] d0_row;
  logic       d1_hs, d1_vs, d1_de, d1_ls, d1_fs;
  logic [9:0] d1_col;
  logic [8:0] d1_row;
  logic       d2_hs, d2_vs, d2_de, d2_ls, d2_fs;
  logic [9:0] d2_col;
  logic [8:0] d2_row;

  controlador_vga d0 (
    .clk(clk), .reset(reset), .hsync(d0_hs), .vsync(d0_vs), .disp_ena(d0_de),
    .col(d0_col), .row(d0_row), .line_start(d0_ls), .frame_start(d0_fs)
  );

  controlador_vga #(.H_POL(1'b1), .V_POL(1'b1)) d1 (
    .clk(clk), .reset(reset), .hsync(d1_hs), .vsync(d1_vs), .disp_ena(d1_de),
    .col(d1_col), .row(d1_row), .line_start(d1_ls), .frame_start(d1_fs)
  );

  // 8+2+3+3 = 16 pixels per line, 6+2+2+2 = 12 lines per frame
  controlador_vga #(
    .H_VISIVEL(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIVEL(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) d2 (
    .clk(clk), .reset(reset), .hsync(d2_hs), .vsync(d2_vs), .disp_ena(d2_de),
    .col(d2_col), .row(d2_row), .line_start(d2_ls), .frame_start(d2_fs)
  );

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({d0_hs, d0_vs, d0_de, d0_col, d0_row, d0_ls, d0_fs} !==
          {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_d0 cycle %0d: got hs=%b vs=%b de=%b col=%0d row=%0d ls=%b fs=%b, want 1 1 0 0 0 0 0",
                 i, d0_hs, d0_vs, d0_de, d0_col, d0_row, d0_ls, d0_fs);
      end
      checks++;
      if ({d1_hs, d1_vs} !== 2'b00) begin
        errors++;
        $display("FAIL reset_d1_sync cycle %0d: got hs=%b vs=%b, want 0 0", i, d1_hs, d1_vs);
      end
    end
    reset = 1'b0;
    k = 0;
    step();
    checks++;
    if ({d0_hs, d0_vs, d0_de, d0_col, d0_row, d0_ls, d0_fs} !==
        {1'b1, 1'b1, 1'b1, 10'd0, 9'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL first_pixel k=1: got hs=%b vs=%b de=%b col=%0d row=%0d ls=%b fs=%b, want 1 1 1 0 0 1 1",
               d0_hs, d0_vs, d0_de, d0_col, d0_row, d0_ls, d0_fs);
    end
  endtask

  // Runs from k=2 through k=1600 (lines 0 and 1), continuing from test_reset
  task automatic test_horizontal();
    int p, h, v;
    logic       e_de, e_hs;
    logic [9:0] e_col;
    logic [8:0] e_row;
    while (k < 1600) begin
      step();
      p = k - 1;
      h = p % 800;
      v = p / 800;
      e_de  = (h < 640);
      e_hs  = !(h >= 656 && h < 752);
      e_col = e_de ? 10'(h) : 10'd0;
      e_row = e_de ? 9'(v) : 9'd0;
      checks++;
      if ({d0_hs, d0_vs, d0_de, d0_col, d0_row, d0_ls, d0_fs} !==
          {e_hs, 1'b1, e_de, e_col, e_row, (h == 0), 1'b0}) begin
        errors++;
        $display("FAIL line_d0 k=%0d: got hs=%b vs=%b de=%b col=%0d row=%0d ls=%b fs=%b, want %b 1 %b %0d %0d %b 0",
                 k, d0_hs, d0_vs, d0_de, d0_col, d0_row, d0_ls, d0_fs, e_hs, e_de, e_col, e_row, (h == 0));
      end
      checks++;
      if ({d1_hs, d1_vs, d1_de, d1_col, d1_row, d1_ls, d1_fs} !==
          {~e_hs, 1'b0, e_de, e_col, e_row, (h == 0), 1'b0}) begin
        errors++;
        $display("FAIL line_d1 k=%0d: got hs=%b vs=%b de=%b col=%0d row=%0d, want %b 0 %b %0d %0d",
                 k, d1_hs, d1_vs, d1_de, d1_col, d1_row, ~e_hs, e_de, e_col, e_row);
      end
      if (k == 640) begin
        checks++;
        if ({d0_de, d0_col} !== {1'b1, 10'd639}) begin
          errors++;
          $display("FAIL last_col k=640: got de=%b col=%0d, want 1 639", d0_de, d0_col);
        end
      end
      if (k == 641) begin
        checks++;
        if ({d0_de, d0_col} !== {1'b0, 10'd0}) begin
          errors++;
          $display("FAIL blank k=641: got de=%b col=%0d, want 0 0", d0_de, d0_col);
        end
      end
      if (k == 656 || k == 753) begin
        checks++;
        if (d0_hs !== 1'b1) begin
          errors++;
          $display("FAIL hsync_edge k=%0d: got %b, want 1", k, d0_hs);
        end
      end
      if (k == 657 || k == 752) begin
        checks++;
        if (d0_hs !== 1'b0) begin
          errors++;
          $display("FAIL hsync_edge k=%0d: got %b, want 0", k, d0_hs);
        end
      end
    end
  endtask

  // Small-timing instance over three full frames plus the next frame start
  task automatic test_vertical();
    int p, h, v, n_fs, n_ls;
    logic       e_de, e_hs, e_vs;
    logic [9:0] e_col;
    logic [8:0] e_row;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    k = 0;
    n_fs = 0;
    n_ls = 0;
    while (k < 576) begin
      step();
      p = k - 1;
      h = p % 16;
      v = (p / 16) % 12;
      e_de  = (h < 8) && (v < 6);
      e_hs  = !(h >= 10 && h < 13);
      e_vs  = !(v >= 8 && v < 10);
      e_col = e_de ? 10'(h) : 10'd0;
      e_row = e_de ? 9'(v) : 9'd0;
      if (d2_fs === 1'b1) n_fs++;
      if (d2_ls === 1'b1) n_ls++;
      checks++;
      if ({d2_hs, d2_vs, d2_de, d2_col, d2_row, d2_ls, d2_fs} !==
          {e_hs, e_vs, e_de, e_col, e_row, (h == 0), (h == 0 && v == 0)}) begin
        errors++;
        $display("FAIL small k=%0d: got hs=%b vs=%b de=%b col=%0d row=%0d ls=%b fs=%b, want %b %b %b %0d %0d %b %b",
                 k, d2_hs, d2_vs, d2_de, d2_col, d2_row, d2_ls, d2_fs,
                 e_hs, e_vs, e_de, e_col, e_row, (h == 0), (h == 0 && v == 0));
      end
      if (k == 88) begin
        checks++;
        if ({d2_de, d2_col, d2_row} !== {1'b1, 10'd7, 9'd5}) begin
          errors++;
          $display("FAIL last_visible k=88: got de=%b col=%0d row=%0d, want 1 7 5", d2_de, d2_col, d2_row);
        end
      end
      if (k == 128 || k == 161) begin
        checks++;
        if (d2_vs !== 1'b1) begin
          errors++;
          $display("FAIL vsync_edge k=%0d: got %b, want 1", k, d2_vs);
        end
      end
      if (k == 129 || k == 160) begin
        checks++;
        if (d2_vs !== 1'b0) begin
          errors++;
          $display("FAIL vsync_edge k=%0d: got %b, want 0", k, d2_vs);
        end
      end
    end
    checks++;
    if (n_fs != 3) begin
      errors++;
      $display("FAIL frame_count: got %0d, want 3", n_fs);
    end
    checks++;
    if (n_ls != 36) begin
      errors++;
      $display("FAIL line_count: got %0d, want 36", n_ls);
    end
    step();
    checks++;
    if ({d2_fs, d2_col, d2_row} !== {1'b1, 10'd0, 9'd0}) begin
      errors++;
      $display("FAIL frame_wrap k=577: got fs=%b col=%0d row=%0d, want 1 0 0", d2_fs, d2_col, d2_row);
    end
  endtask

  // One-cycle reset in the middle of line 6 of the default instance
  task automatic test_mid_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    k = 0;
    while (k < 5000) step();
    checks++;
    if ({d0_de, d0_col, d0_row} !== {1'b1, 10'd199, 9'd6}) begin
      errors++;
      $display("FAIL pre_reset k=5000: got de=%b col=%0d row=%0d, want 1 199 6", d0_de, d0_col, d0_row);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({d0_hs, d0_vs, d0_de, d0_col, d0_row, d0_ls, d0_fs} !==
        {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_values: got hs=%b vs=%b de=%b col=%0d row=%0d ls=%b fs=%b, want 1 1 0 0 0 0 0",
               d0_hs, d0_vs, d0_de, d0_col, d0_row, d0_ls, d0_fs);
    end
    checks++;
    if ({d1_hs, d1_vs, d1_de} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_d1: got hs=%b vs=%b de=%b, want 0 0 0", d1_hs, d1_vs, d1_de);
    end
    k = 0;
    step();
    checks++;
    if ({d0_hs, d0_vs, d0_de, d0_col, d0_row, d0_ls, d0_fs} !==
        {1'b1, 1'b1, 1'b1, 10'd0, 9'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL restart k=1: got hs=%b vs=%b de=%b col=%0d row=%0d ls=%b fs=%b, want 1 1 1 0 0 1 1",
               d0_hs, d0_vs, d0_de, d0_col, d0_row, d0_ls, d0_fs);
    end
    step();
    checks++;
    if ({d0_de, d0_col, d0_row, d0_ls, d0_fs} !== {1'b1, 10'd1, 9'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL restart k=2: got de=%b col=%0d row=%0d ls=%b fs=%b, want 1 1 0 0 0",
               d0_de, d0_col, d0_row, d0_ls, d0_fs);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_vga.md
CONTROLADOR_VGA -- requirements
Module: controlador_vga

Interface
REQ-001 Parameter H_VISIVEL, default 640, SHALL set the visible pixels per line.
REQ-002 Parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, SHALL set the horizontal front porch, sync and back porch in pixels; H_TOTAL = 800.
REQ-003 Parameters V_VISIVEL, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, SHALL set the vertical equivalents in lines; V_TOTAL = 525.
REQ-004 Parameters H_POL and V_POL, default 0, SHALL set the active sync level (0 = active-low).
REQ-005 clk  in  1  pixel clock; the block has one clock and all logic is on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 hsync  out  1  horizontal sync to the connector.
REQ-008 vsync  out  1  vertical sync to the connector.
REQ-009 disp_ena  out  1  high only while the pixel is inside the visible area.
REQ-010 col  out  10  visible column 0..639, feeds the pixel-colouring stage.
REQ-011 row  out  9  visible row 0..479, feeds the pixel-colouring stage.
REQ-012 line_start  out  1  one-cycle pulse at the first pixel of every line.
REQ-013 frame_start  out  1  one-cycle pulse at pixel (0,0) of every frame.

Function
REQ-014 The block SHALL keep an internal horizontal counter h (0..H_TOTAL-1) and a vertical counter v (0..V_TOTAL-1), each 10 bits wide.
REQ-015 h SHALL increment every clk; at H_TOTAL-1 it SHALL wrap to 0 and v SHALL increment in the same cycle.
REQ-016 v SHALL wrap from V_TOTAL-1 to 0 when h wraps.
REQ-017 All outputs SHALL be registered and SHALL reflect position P = k-1 on the k-th rising edge after reset deasserts (k = 1, 2, ...), with h = P mod 800 and v = (P div 800) mod 525.
REQ-018 disp_ena SHALL be 1 iff h < H_VISIVEL and v < V_VISIVEL.
REQ-019 col SHALL equal h when disp_ena = 1 and 0 otherwise; row SHALL equal v[8:0] when disp_ena = 1 and 0 otherwise.
REQ-020 hsync SHALL be at active level iff H_VISIVEL+H_FP <= h < H_VISIVEL+H_FP+H_SYNC (656..751 by default).
REQ-021 vsync SHALL be at active level iff V_VISIVEL+V_FP <= v < V_VISIVEL+V_FP+V_SYNC (490..491 by default), independent of h.
REQ-022 line_start SHALL be 1 iff h = 0; frame_start SHALL be 1 iff h = 0 and v = 0.
REQ-023 No counter SHALL ever exceed its TOTAL-1 value; no value outside REQ-019 ranges SHALL appear on col or row.
REQ-024 Output timing SHALL be fixed at one cycle from counter state; all outputs SHALL change on the same edge (no skew between sync, disp_ena and col/row).

Reset
REQ-025 While reset is high at a rising edge, h and v SHALL become 0.
REQ-026 At the same edge, hsync and vsync SHALL go to their inactive level (1 with default polarity).
REQ-027 At the same edge, disp_ena, col, row, line_start and frame_start SHALL go to 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release, timing SHALL restart exactly as in REQ-017 from k = 1.
REQ-029 Holding reset for several cycles SHALL keep all outputs at their reset values.

Verification
REQ-030 Apply reset for 3 cycles, then check: hsync=1, vsync=1, disp_ena=0, col=0, row=0 during reset; on edge k=1, disp_ena=1, col=0, row=0, line_start=1, frame_start=1.
REQ-031 Check horizontal blanking: on edge k=640, col=639 and disp_ena=1; on edge k=641, disp_ena=0 and col=0; hsync is 0 on edges k=657..752 only and is 1 at k=656 and k=753.
REQ-032 Check vertical sync: vsync is 0 from edge k=392001 (v=490, h=0) through edge k=393600, and 1 at edges 392000 and 393601; on the last visible pixel (k=383840), row=479 and col=639.
REQ-033 Check frame wrap: on edge k=420001, frame_start=1, col=0, row=0; frame_start pulses exactly once per 420000 cycles over 3 frames; line_start pulses exactly 525 times per frame.
REQ-034 Assert reset for 1 cycle at an arbitrary edge (for example k=100000, inside line 124); check that the next output values equal the reset values and that the sequence after release equals the REQ-030 sequence.
REQ-035 Rebuild with H_POL=1 and V_POL=1; check that hsync and vsync are inverted and that all other outputs are unchanged.
